// File: rtl/spi_master_fifo.sv
// spi_master_fifo: Wishbone SPI master with TX/RX FIFOs, configurable frame
// width, one-hot active-low chip selects and level interrupts.
//
// Ports:
//   wb_clk_i, arst_n_i       clock (rising edge), asynchronous active-low reset
//   wb_adr_i/dat_i/we_i      register address, write data, write enable
//   wb_stb_i, wb_cyc_i       bus strobe / cycle; wb_ack_o = cyc & stb
//   wb_dat_o                 read data, combinational from wb_adr_i
//   wb_inta_o                level interrupt, active high
//   MISO_i, MOSI_o, SCLK_o   SPI serial lines
//   SSn_o                    NUM_CS active-low slave selects
//   TIP_o                    transfer engine not IDLE (also the FSM observation point)
//
// Bus handshake: a register access is acc = wb_cyc_i & wb_stb_i and completes in
// the same cycle (wb_ack_o = acc); writes take effect on the next rising edge,
// RXDATA reads pop on that same edge.
module spi_master_fifo #(
  parameter int FRAME_W = 8,
  parameter int DEPTH   = 8,
  parameter int NUM_CS  = 8,
  parameter int DW      = 32
) (
  input  logic              wb_clk_i,
  input  logic              arst_n_i,
  input  logic [2:0]        wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              wb_inta_o,
  input  logic              MISO_i,
  output logic              MOSI_o,
  output logic              SCLK_o,
  output logic [NUM_CS-1:0] SSn_o,
  output logic              TIP_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(2 * FRAME_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * FRAME_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // Registers
  logic [4:0]        ctrl_q;
  logic [15:0]       div_q;
  logic [NUM_CS-1:0] cs_q;
  logic [2:0]        ier_q;
  logic              tx_ovf_q, rx_ovf_q;

  // Per-frame copies of the configuration (CPOL only follows in IDLE)
  logic              cpol_act_q, cpha_act_q, lsbfe_act_q, autocs_act_q;
  logic [15:0]       div_act_q;

  // Engine
  logic [2:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [EW-1:0]      edge_q, edge_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic               start, tx_pop, rx_push;

  // FIFOs: pointers carry an extra wrap bit to tell full from empty
  logic [FRAME_W-1:0] tx_mem [DEPTH];
  logic [FRAME_W-1:0] rx_mem [DEPTH];
  logic [AW:0]        tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic               tx_empty, tx_full, rx_empty, rx_full;
  logic [FRAME_W-1:0] tx_head, rx_head;

  logic acc, wr_en, rd_en;
  logic tx_push, tx_push_ok, rx_pop, rx_push_ok;
  logic tx_ovf_set, rx_ovf_set;
  logic spe, busy, half_done;
  logic unused_bits;

  assign acc      = wb_cyc_i & wb_stb_i;
  assign wr_en    = acc & wb_we_i;
  assign rd_en    = acc & ~wb_we_i;
  assign wb_ack_o = acc;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
  assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle
  assign tx_push    = wr_en && (wb_adr_i == 3'd4);
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign tx_ovf_set = tx_push && tx_full && !tx_pop;
  assign rx_pop     = rd_en && (wb_adr_i == 3'd5) && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_push && rx_full && !rx_pop;

  assign spe       = ctrl_q[0];
  assign busy      = (state_q != S_IDLE);
  assign TIP_o     = busy;
  assign half_done = (cnt_q == 16'd0);

  assign unused_bits = ^wb_dat_i;

  // Engine next-state logic
  always_comb begin
    logic [EW-1:0] next_edge;
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    start     = 1'b0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    next_edge = edge_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (spe && !tx_empty) begin
          start   = 1'b1;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (half_done) begin
          // First leading edge; with CPHA=1 bit 0 is already on MOSI, so nothing shifts
          state_d = S_SHIFT;
          edge_d  = '0;
          if (!cpha_act_q)
            rx_sh_d = lsbfe_act_q ? {MISO_i, rx_sh_q[FRAME_W-1:1]} : {rx_sh_q[FRAME_W-2:0], MISO_i};
        end
      end
      S_SHIFT: begin
        if (half_done) begin
          if (edge_q == LAST_EDGE) begin
            state_d = S_TRAIL;
            rx_push = 1'b1;
          end else begin
            edge_d = next_edge;
            // Odd half-period index = trailing edge, even = leading edge
            if (next_edge[0] ^ cpha_act_q)
              tx_sh_d = lsbfe_act_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            else
              rx_sh_d = lsbfe_act_q ? {MISO_i, rx_sh_q[FRAME_W-1:1]} : {rx_sh_q[FRAME_W-2:0], MISO_i};
          end
        end
      end
      S_TRAIL: begin
        if (half_done) begin
          if (spe && !tx_empty) begin
            start   = 1'b1;
            state_d = S_LEAD;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (half_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      tx_pop  = 1'b1;
      tx_sh_d = tx_head;
      rx_sh_d = '0;
    end

    // Divider reloads on every state entry and every SHIFT half-period
    if (start)
      cnt_d = div_q;
    else if (state_q != S_IDLE)
      cnt_d = half_done ? div_act_q : (cnt_q - 16'd1);
  end

  always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      edge_q       <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      cpol_act_q   <= 1'b0;
      cpha_act_q   <= 1'b0;
      lsbfe_act_q  <= 1'b0;
      autocs_act_q <= 1'b0;
      div_act_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      if (state_q == S_IDLE) cpol_act_q <= ctrl_q[1];
      if (start) begin
        cpha_act_q   <= ctrl_q[2];
        lsbfe_act_q  <= ctrl_q[3];
        autocs_act_q <= ctrl_q[4];
        div_act_q    <= div_q;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ctrl_q   <= '0;
      div_q    <= '0;
      cs_q     <= '0;
      ier_q    <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
    end else begin
      if (wr_en && wb_adr_i == 3'd0) ctrl_q <= wb_dat_i[4:0];
      if (wr_en && wb_adr_i == 3'd1) div_q  <= wb_dat_i[15:0];
      if (wr_en && wb_adr_i == 3'd2) cs_q   <= wb_dat_i[NUM_CS-1:0];
      if (wr_en && wb_adr_i == 3'd6) ier_q  <= wb_dat_i[2:0];
      // Setting wins over a same-cycle write-one-to-clear
      tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~(wr_en && wb_adr_i == 3'd3 && wb_dat_i[5]));
      rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~(wr_en && wb_adr_i == 3'd3 && wb_dat_i[6]));
      if (tx_push_ok) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)     tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)     rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (tx_push_ok) tx_mem[tx_wr_q[AW-1:0]] <= wb_dat_i[FRAME_W-1:0];
    if (rx_push_ok) rx_mem[rx_wr_q[AW-1:0]] <= rx_sh_q;
  end

  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i)
      3'd0: wb_dat_o[4:0]         = ctrl_q;
      3'd1: wb_dat_o[15:0]        = div_q;
      3'd2: wb_dat_o[NUM_CS-1:0]  = cs_q;
      3'd3: wb_dat_o[6:0]         = {rx_ovf_q, tx_ovf_q, busy, rx_full, rx_empty, tx_full, tx_empty};
      3'd5: wb_dat_o[FRAME_W-1:0] = rx_empty ? '0 : rx_head;
      3'd6: wb_dat_o[2:0]         = ier_q;
      default: wb_dat_o = '0;
    endcase
  end

  assign wb_inta_o = (ier_q[0] & tx_empty & ~busy) | (ier_q[1] & ~rx_empty) |
                     (ier_q[2] & (tx_ovf_q | rx_ovf_q));

  // With AUTOCS, selects are only driven while a frame is on the wire; in IDLE the
  // live CTRL bit decides, otherwise the copy taken at frame start.
  always_comb begin
    logic autocs_eff, frame_on;
    autocs_eff = (state_q == S_IDLE) ? ctrl_q[4] : autocs_act_q;
    frame_on   = (state_q == S_LEAD) || (state_q == S_SHIFT) || (state_q == S_TRAIL);
    SSn_o      = (!autocs_eff || frame_on) ? ~cs_q : '1;
  end

  // Even half-period index carries the non-idle level
  assign SCLK_o = (state_q == S_SHIFT) ? (cpol_act_q ^ ~edge_q[0]) : cpol_act_q;
  assign MOSI_o = lsbfe_act_q ? tx_sh_q[0] : tx_sh_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_master_fifo.sv
module tb_spi_master_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // ---------------- bus and DUT wiring ----------------
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic        wb_we, wb_stb, cyc8, cyc16;
  logic [31:0] dat8, dat16;
  logic        ack8, ack16, inta8, inta16;
  logic        mosi8, sclk8, tip8, miso8;
  logic        mosi16, sclk16, tip16, miso16;
  logic [7:0]  ssn8;
  logic [1:0]  ssn16;

  assign miso8  = mosi8;
  assign miso16 = mosi16;

  spi_master_fifo #(.FRAME_W(8), .DEPTH(4), .NUM_CS(8), .DW(32)) u_dut (
    .wb_clk_i(clk), .arst_n_i(arst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
    .wb_dat_o(dat8), .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(cyc8),
    .wb_ack_o(ack8), .wb_inta_o(inta8), .MISO_i(miso8), .MOSI_o(mosi8),
    .SCLK_o(sclk8), .SSn_o(ssn8), .TIP_o(tip8)
  );

  spi_master_fifo #(.FRAME_W(16), .DEPTH(4), .NUM_CS(2), .DW(32)) u_dut16 (
    .wb_clk_i(clk), .arst_n_i(arst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
    .wb_dat_o(dat16), .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(cyc16),
    .wb_ack_o(ack16), .wb_inta_o(inta16), .MISO_i(miso16), .MOSI_o(mosi16),
    .SCLK_o(sclk16), .SSn_o(ssn16), .TIP_o(tip16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];       // frames expected in the 8-bit RX FIFO
  logic [7:0] exp_wire_q[$];  // frames expected on the 8-bit wire

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- 8-bit wire monitor (acts as the slave) ----------------
  logic       mon_en = 1'b0;
  logic       m_cpol, m_cpha, m_lsbfe;
  int         m_div;
  logic [7:0] exp_ssn;
  logic       sclk_prev = 1'b0;
  logic [7:0] ssn_prev = 8'hFF;
  logic       mon_lead;
  logic [7:0] wire_w;
  int         bit_n, pulses, since, ssn_falls;

  always @(negedge clk) begin
    if (mon_en) begin
      since++;
      if (ssn8 != 8'hFF && ssn_prev == 8'hFF) ssn_falls++;
      if (sclk8 != sclk_prev) begin
        mon_lead = (sclk8 != m_cpol);
        check("ssn_during_sclk", ssn8, exp_ssn);
        if (mon_lead) pulses++;
        else check("sclk_pulse_width", since, m_div + 1);
        if (mon_lead != m_cpha) begin
          wire_w = m_lsbfe ? {mosi8, wire_w[7:1]} : {wire_w[6:0], mosi8};
          bit_n++;
          if (bit_n == 8) begin
            bit_n = 0;
            check("wire_frame_expected", exp_wire_q.size() > 0, 1);
            if (exp_wire_q.size() > 0) check("wire_frame", wire_w, exp_wire_q.pop_front());
          end
        end
        since = 0;
      end
    end
    sclk_prev = sclk8;
    ssn_prev  = ssn8;
  end

  // ---------------- 16-bit SCLK timing monitor (CPOL=0) ----------------
  logic mon16_en = 1'b0;
  logic sclk16_prev = 1'b0;
  int   p16, since16;

  always @(negedge clk) begin
    if (mon16_en) begin
      since16++;
      if (sclk16 != sclk16_prev) begin
        if (sclk16) begin
          if (p16 > 0) check("t5_sclk_low", since16, 4);
          p16++;
        end else begin
          check("t5_sclk_high", since16, 4);
        end
        since16 = 0;
      end
    end
    sclk16_prev = sclk16;
  end

  // ---------------- driver tasks ----------------
  task automatic wb_write(input int sel, input logic [2:0] adr, input logic [31:0] dat);
    @(negedge clk);
    wb_adr = adr; wb_dat_w = dat; wb_we = 1'b1; wb_stb = 1'b1;
    if (sel == 0) cyc8 = 1'b1; else cyc16 = 1'b1;
    @(negedge clk);
    wb_we = 1'b0; wb_stb = 1'b0; cyc8 = 1'b0; cyc16 = 1'b0;
  endtask

  task automatic wb_read(input int sel, input logic [2:0] adr, output logic [31:0] dat);
    @(negedge clk);
    wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1;
    if (sel == 0) cyc8 = 1'b1; else cyc16 = 1'b1;
    #1;
    dat = (sel == 0) ? dat8 : dat16;
    check("wb_ack", (sel == 0) ? ack8 : ack16, 1);
    @(negedge clk);
    wb_stb = 1'b0; cyc8 = 1'b0; cyc16 = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d, input bit on_wire, input bit into_rx);
    wb_write(0, 3'd4, {24'd0, d});
    if (on_wire) exp_wire_q.push_back(d);
    if (into_rx) exp_q.push_back(d);
  endtask

  task automatic read_rx();
    logic [31:0] d;
    wb_read(0, 3'd5, d);
    check("rx_sb_has_entry", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) check("rx_data", d, {24'd0, exp_q.pop_front()});
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe,
                          input int div, input logic [7:0] ssn);
    repeat (2) @(negedge clk);
    m_cpol = cpol; m_cpha = cpha; m_lsbfe = lsbfe; m_div = div; exp_ssn = ssn;
    pulses = 0; bit_n = 0; since = 0; ssn_falls = 0;
    mon_en = 1'b1;
  endtask

  task automatic wait_idle(input int sel, input string tag, output int n);
    logic t;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      t = (sel == 0) ? tip8 : tip16;
      if (t) n++;
      else if (n > 0) break;
    end
    check(tag, (sel == 0) ? tip8 : tip16, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int n;
    wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_stb = 1'b0; cyc8 = 1'b0; cyc16 = 1'b0;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ssn", ssn8, 8'hFF);
    check("rst_sclk", sclk8, 0);
    check("rst_mosi", mosi8, 0);
    check("rst_tip", tip8, 0);
    check("rst_inta", inta8, 0);
    arst_n = 1'b1;
    wb_read(0, 3'd3, d); check("rst_stat", d, 32'h05);
    wb_read(0, 3'd0, d); check("rst_ctrl", d, 0);

    // 1: mode 0, DIV=0, single frame with loopback
    wb_write(0, 3'd1, 0);
    wb_write(0, 3'd2, 1);
    wb_write(0, 3'd0, 32'h01);
    set_mode(0, 0, 0, 0, 8'hFE);
    check("t1_ssn_idle", ssn8, 8'hFE);
    write_tx(8'hA5, 1, 1);
    @(negedge clk);
    check("t1_tip_after_pop", tip8, 1);
    wait_idle(0, "t1_idle", n);
    check("t1_tip_cycles", n + 1, 19);
    check("t1_pulses", pulses, 8);
    read_rx();

    // 2: CPOL=1 CPHA=1 LSB first, AUTOCS, two back-to-back frames
    mon_en = 1'b0;
    wb_write(0, 3'd0, 32'h1F);
    set_mode(1, 1, 1, 0, 8'hFE);
    check("t2_sclk_idle_high", sclk8, 1);
    check("t2_ssn_idle", ssn8, 8'hFF);
    write_tx(8'h01, 1, 1);
    write_tx(8'h80, 1, 1);
    wait_idle(0, "t2_idle", n);
    check("t2_ssn_falls", ssn_falls, 1);
    check("t2_ssn_after_gap", ssn8, 8'hFF);
    check("t2_pulses", pulses, 16);
    read_rx();
    read_rx();

    // 3: SPE=0, overfill TX, overflow flag and interrupt
    mon_en = 1'b0;
    wb_write(0, 3'd0, 32'h00);
    set_mode(0, 0, 0, 0, 8'hFE);
    for (int i = 0; i < 4; i++) write_tx(8'($urandom_range(0, 255)), 1, 1);
    write_tx(8'($urandom_range(0, 255)), 0, 0);
    wb_read(0, 3'd3, d); check("t3_stat_full_ovf", d, 32'h26);
    wb_write(0, 3'd6, 32'h4);
    check("t3_inta_ovf", inta8, 1);
    wb_write(0, 3'd3, 32'h20);
    wb_read(0, 3'd3, d); check("t3_stat_cleared", d, 32'h06);
    check("t3_inta_fell", inta8, 0);

    // 4: drain TX into RX until full, then one more frame overflows RX
    wb_write(0, 3'd0, 32'h01);
    wait_idle(0, "t4_idle_a", n);
    wb_read(0, 3'd3, d); check("t4_stat_rx_full", d, 32'h09);
    wb_write(0, 3'd6, 32'h2);
    check("t4_inta_rx", inta8, 1);
    write_tx(8'($urandom_range(0, 255)), 1, 0);
    wait_idle(0, "t4_idle_b", n);
    wb_read(0, 3'd3, d); check("t4_stat_rx_ovf", d, 32'h49);
    wb_write(0, 3'd6, 32'h4);
    check("t4_inta_rx_ovf", inta8, 1);
    for (int i = 0; i < 4; i++) read_rx();
    wb_read(0, 3'd5, d); check("t4_rx_empty_read", d, 0);
    wb_read(0, 3'd3, d); check("t4_stat_drained", d, 32'h45);
    wb_write(0, 3'd3, 32'h40);
    wb_read(0, 3'd3, d); check("t4_stat_w1c", d, 32'h05);
    wb_write(0, 3'd6, 32'h1);
    check("t4_inta_tx_empty", inta8, 1);
    wb_write(0, 3'd6, 32'h0);
    check("t4_inta_masked", inta8, 0);
    check("wire_queue_drained", exp_wire_q.size(), 0);
    check("rx_queue_drained", exp_q.size(), 0);

    // 5: 16-bit frame, DIV=3
    mon_en = 1'b0;
    wb_write(1, 3'd1, 3);
    wb_write(1, 3'd2, 1);
    wb_write(1, 3'd0, 32'h01);
    p16 = 0; since16 = 0; mon16_en = 1'b1;
    wb_write(1, 3'd4, 32'h1234);
    wait_idle(1, "t5_idle", n);
    check("t5_tip_cycles", n, 140);
    check("t5_pulses", p16, 16);
    check("t5_ssn", ssn16, 2'b10);
    wb_read(1, 3'd5, d); check("t5_rx", d, 32'h1234);
    mon16_en = 1'b0;

    // 6: reset in the middle of SHIFT
    wb_write(0, 3'd1, 1);
    wb_write(0, 3'd0, 32'h03);
    write_tx(8'h5A, 0, 0);
    write_tx(8'h3C, 0, 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sclk8 == 1'b0) break;
    end
    check("t6_in_shift", sclk8, 0);
    check("t6_busy", tip8, 1);
    #2 arst_n = 1'b0;
    #1;
    check("t6_sclk", sclk8, 0);
    check("t6_ssn", ssn8, 8'hFF);
    check("t6_tip", tip8, 0);
    check("t6_mosi", mosi8, 0);
    check("t6_inta", inta8, 0);
    @(negedge clk);
    arst_n = 1'b1;
    wb_read(0, 3'd3, d); check("t6_stat", d, 32'h05);
    wb_read(0, 3'd0, d); check("t6_ctrl", d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
Parametrised successor to the single-byte Wishbone SPI master. Adds the following:
- Configurable frame width.
- TX and RX FIFOs of configurable depth.
- N one-hot chip selects with an automatic chip-select mode.
- Back-to-back frames without CPU intervention.
- Level-based interrupts.

It sits on the FCB Wishbone register bus and drives external SPI flash and peripherals.

Parameters:
FRAME_W, 8, bits per SPI frame (4..32)
DEPTH, 8, entries per TX and RX FIFO (power of 2, 2..64)
NUM_CS, 8, number of active-low slave selects (1..8)
DW, 32, Wishbone data width (must be >= FRAME_W and >= 16)

Ports:
wb_clk_i  in  1  sole clock; all logic is on the rising edge
arst_n_i  in  1  asynchronous active-low reset
wb_adr_i  in  3  register address
wb_dat_i  in  DW  write data
wb_dat_o  out  DW  read data (combinational from wb_adr_i)
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle valid
wb_ack_o  out  1  wb_cyc_i & wb_stb_i (zero wait state)
wb_inta_o  out  1  interrupt, level, active high
MISO_i  in  1  serial input
MOSI_o  out  1  serial output
SCLK_o  out  1  serial clock
SSn_o  out  NUM_CS  slave selects, active low
TIP_o  out  1  transfer engine not IDLE

Behaviour:
- Access strobe: acc = wb_cyc_i & wb_stb_i. Writes take effect on acc & we; pops on acc & ~we.
- Register 0, CTRL (RW, reset 0): [0] SPE, [1] CPOL, [2] CPHA, [3] LSBFE, [4] AUTOCS.
- Register 1, DIV (RW, reset 0): [15:0]. SCLK half-period = DIV+1 clocks.
- Register 2, CS (RW, reset 0): [NUM_CS-1:0] one-hot select.
- Register 3, STAT (RO, except W1C bits):
  - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full.
  - [4] busy (= TIP_o).
  - [5] tx_ovf, sticky, W1C.
  - [6] rx_ovf, sticky, W1C.
- Register 4, TXDATA (WO): write pushes wb_dat_i[FRAME_W-1:0]. Reads return 0.
- Register 5, RXDATA (RO): read returns the head entry, zero-extended, and pops it. Reading when empty returns 0 and causes no pointer change.
- Register 6, IER (RW, reset 0): [0] tx_empty, [1] rx_not_empty, [2] overflow.
- Register 7: reads 0.
- wb_inta_o = (IER0 & tx_empty & ~busy) | (IER1 & ~rx_empty) | (IER2 & (tx_ovf | rx_ovf)).
- FIFOs use pointers with an extra wrap bit. Count is DEPTH when full.
  - Push when full: data dropped, tx_ovf set.
  - Simultaneous push and pop on a full or empty FIFO are both legal; count is unchanged.
- Engine FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
  - IDLE: if SPE & ~tx_empty, pop TX into the shift register and go to LEAD.
  - LEAD: 1 half-period with SSn asserted and SCLK = CPOL. MOSI holds bit 0 of the order: MSB if LSBFE=0, LSB if LSBFE=1.
  - SHIFT: 2*FRAME_W half-periods. The first edge of each pair is leading, the second trailing.
    - CPHA=0: sample MISO on the leading edge, shift MOSI on the trailing edge.
    - CPHA=1: drive MOSI on the leading edge, sample on the trailing edge.
  - TRAIL: 1 half-period, SCLK = CPOL. At entry, push the received frame to RX. If RX is full, drop it and set rx_ovf.
  - After TRAIL: if SPE & ~tx_empty, pop and go to LEAD (AUTOCS keeps SSn asserted). Otherwise go to GAP.
  - GAP: 1 half-period with SSn deasserted when AUTOCS=1, then IDLE.
- SSn_o:
  - AUTOCS=0: SSn_o = ~CS continuously.
  - AUTOCS=1: SSn_o = ~CS only in LEAD, SHIFT or TRAIL; all ones otherwise.
- SCLK_o = CPOL outside SHIFT. CTRL and DIV writes during a transfer apply from the next frame; CPOL changes apply in IDLE only.
- Divider counter reloads on every state entry.
- SPE cleared mid-frame: finish the current frame, then go to IDLE. The TX FIFO is not flushed.
- Reset values:
  - SSn_o all ones, SCLK_o=0, MOSI_o=0, TIP_o=0, wb_inta_o=0.
  - FIFOs empty, all registers 0.
  - Asserting reset mid-frame aborts immediately to these values.

Test Plan:
1. DIV=0, CTRL=0x01, CS=0x01, TXDATA=0xA5 with MISO looped to MOSI: 8 SCLK pulses, each high 1 clock; MOSI sequence 1,0,1,0,0,1,0,1; RXDATA reads 0xA5; SSn_o=0xFE throughout.
2. CTRL=0x1F (CPOL=1, CPHA=1, LSBFE=1, AUTOCS=1), push 0x01, 0x80: SCLK idles high; LSB is first on the wire; SSn stays low across both frames, then 0xFF after GAP; RX contains 0x01, 0x80.
3. With SPE=0, push DEPTH+1 words: STAT tx_full=1 and tx_ovf=1; writing 0x20 to STAT clears tx_ovf; with IER=0x4, wb_inta_o falls.
4. With RX pre-filled to DEPTH, send 1 frame: rx_ovf=1; RX contents unchanged.
5. FRAME_W=16, DIV=3, push 0x1234: 16 pulses of 8-clock period; RX=0x1234 (loopback); TIP_o=1 from the pop until IDLE.
6. Deassert arst_n_i during SHIFT: SCLK_o, SSn_o and FIFOs return to reset values within the same cycle; TIP_o=0.
